cla_pipe_adder: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit combinational CLA.
- Splits a WIDTH-bit operation into NSEG = WIDTH/SEG_WIDTH lookahead segments, one segment per pipeline stage.
- Carry ripples between stages through registers; operands enter via a valid/ready handshake with full backpressure.
- Feeds the ALU datapath where 32/64-bit adds must close timing at high clock rates.

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_seg.sv | 74 +++++++
 rtl/cla_pipe_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of lookahead segments, one per pipeline stage.
    function automatic int cla_nseg(input int width, input int seg);
        return (width / seg < 1) ? 1 : width / seg;
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational W-bit carry-lookahead segment: 4-bit lookahead groups plus a
// second lookahead level across the groups.
module cla_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         gm,
    output logic         pm
);

    localparam int NG = (W + 3) / 4;
    localparam int WP = NG * 4;

    logic [WP-1:0] ap, bp, p, g, c, sp;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          acc, pacc;

    always_comb begin
        // Pad bits propagate (p=1, g=0) so a partial top group passes its carry out.
        ap = '1;
        bp = '0;
        ap[W-1:0] = a;
        bp[W-1:0] = b;
        p = ap ^ bp;
        g = ap & bp;

        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end

        acc   = 1'b0;
        pacc  = 1'b0;
        gc    = '0;
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            acc  = gg[j];
            pacc = gp[j];
            for (int i = j - 1; i >= 0; i--) begin
                acc  = acc | (pacc & gg[i]);
                pacc = pacc & gp[i];
            end
            gc[j+1] = acc | (pacc & ci);
        end
        gm = acc;
        pm = pacc;

        c = '0;
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end

        sp = p ^ c;
        s  = sp[W-1:0];
        co = gc[NG];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one SEG_WIDTH lookahead segment per stage,
// carry registered between stages, global stall on output backpressure.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG = cla_nseg(WIDTH, SEG_WIDTH);
    localparam int SW   = SEG_WIDTH;

    if (WIDTH % SEG_WIDTH != 0) begin : g_width_chk
        $error("cla_pipe_adder: WIDTH %0d is not a multiple of SEG_WIDTH %0d", WIDTH, SEG_WIDTH);
    end

    logic [NSEG-1:0]  vld_pipe;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             stall;

    assign out_valid = vld_pipe[NSEG-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // Subtraction is a + ~b + 1; the caller's ci only matters for adds.
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign c_eff = (op == OP_SUB) ? 1'b1 : ci;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (!stall)
            vld_pipe <= (vld_pipe << 1) | NSEG'(in_valid);
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SW;        // result bits already resolved
        localparam int HI = WIDTH - LO;    // operand bits still pending

        logic [HI-1:0]    a_in, b_in;
        logic             c_in;
        logic [SW-1:0]    seg_s;
        logic             seg_co, seg_gm, seg_pm;
        logic [LO+SW-1:0] s_cat, s_r;

        if (k == 0) begin : g_head
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = c_eff;
            assign s_cat = seg_s;
        end else begin : g_tail
            assign a_in  = g_stage[k-1].g_fwd.a_r;
            assign b_in  = g_stage[k-1].g_fwd.b_r;
            assign c_in  = g_stage[k-1].g_fwd.c_r;
            assign s_cat = {seg_s, g_stage[k-1].s_r};
        end

        cla_seg #(.W(SW)) u_seg (
            .a  (a_in[SW-1:0]),
            .b  (b_in[SW-1:0]),
            .ci (c_in),
            .s  (seg_s),
            .co (seg_co),
            .gm (seg_gm),
            .pm (seg_pm)
        );

        // Group generate/propagate must agree with the segment's own carry out.
        always_ff @(posedge clk) begin
            assert (seg_co == (seg_gm | (seg_pm & c_in)));
        end

        // Completed low sum bits grow by one slice per stage (de-skew).
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                s_r <= '0;
            else if (!stall)
                s_r <= s_cat;
        end

        if (k < NSEG - 1) begin : g_fwd
            // Only the operand bits not yet consumed travel onward (skew).
            logic [HI-SW-1:0] a_r, b_r;
            logic             c_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                end else if (!stall) begin
                    a_r <= a_in[HI-1:SW];
                    b_r <= b_in[HI-1:SW];
                    c_r <= seg_co;
                end
            end
        end else begin : g_last
            logic co_r, ovf_r, zero_r;
            logic msb_ci;

            // Carry into the MSB recovered from its sum bit.
            assign msb_ci = a_in[HI-1] ^ b_in[HI-1] ^ seg_s[SW-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    co_r   <= 1'b0;
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (!stall) begin
                    co_r   <= seg_co;
                    ovf_r  <= seg_co ^ msb_ci;
                    zero_r <= (s_cat == '0);
                end
            end
        end
    end

    assign s    = g_stage[NSEG-1].s_r;
    assign co   = g_stage[NSEG-1].g_last.co_r;
    assign ovf  = g_stage[NSEG-1].g_last.ovf_r;
    assign zero = g_stage[NSEG-1].g_last.zero_r;

endmodule
